jump_fall_ctrl: RTL and testbench

//  Vertical-motion sequencer for the player sprite. Runs the ground/rise/fall FSM

---
 rtl/jump_fall_ctrl.sv | 139 +++++++++++++
 tb/tb_jump_fall_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_fall_ctrl.sv
// jump_fall_ctrl: ground/rise/fall sequencer emitting vertical step pulses with double jump and accelerating fall
module jump_fall_ctrl #(
    parameter int MAX_JUMPS      = 2,
    parameter int JUMP_STEPS     = 24,
    parameter int MIN_RISE_STEPS = 6,
    parameter int RISE_INV       = 3,
    parameter int FALL_INV_START = 6,
    parameter int FALL_INV_MIN   = 2,
    parameter int ACCEL_STEPS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       jump_key,
    input  logic       on_ground,
    input  logic       hit_ceiling,
    input  logic       pause,
    output logic [1:0] dir_y,
    output logic [1:0] air_action,
    output logic       is_up,
    output logic       is_down,
    output logic [1:0] jumps_left
);
    localparam int IMAX = RISE_INV > FALL_INV_START ? RISE_INV : FALL_INV_START;
    localparam int IW   = $clog2(IMAX + 1);
    localparam int RW   = $clog2(JUMP_STEPS + 1);
    localparam int AW   = ACCEL_STEPS > 1 ? $clog2(ACCEL_STEPS) : 1;

    typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

    state_t        r_state, w_state;
    logic [IW-1:0] r_cnt, w_cnt, r_finv, w_finv;
    logic [RW-1:0] r_rise, w_rise;
    logic [AW-1:0] r_fstep, w_fstep;
    logic [1:0]    r_jl, w_jl;
    logic          r_prev, r_up, w_up, r_down, w_down, w_edge, w_enter, w_accel;

    always_ff @(posedge clk) begin
        r_state <= rst ? GROUND : w_state;
    end

    always_comb begin
        w_edge  = jump_key & ~r_prev;
        w_state = r_state;
        w_enter = 1'b0;
        w_jl    = r_jl;
        w_up    = 1'b0;
        w_down  = 1'b0;
        w_cnt   = r_cnt;
        w_rise  = r_rise;
        w_fstep = r_fstep;
        w_finv  = r_finv;
        w_accel = r_fstep == AW'(ACCEL_STEPS - 1);
        if (!pause) begin
            case (r_state)
                GROUND: begin
                    if (w_edge || !on_ground) begin
                        w_state = w_edge ? RISE : FALL;
                        w_enter = 1'b1;
                        w_jl    = 2'(MAX_JUMPS - 1);
                    end
                end
                RISE: begin
                    if (hit_ceiling) begin
                        w_state = FALL;
                        w_enter = 1'b1;
                    end else if (w_edge && r_jl != 2'd0) begin
                        w_enter = 1'b1;
                        w_jl    = r_jl - 2'd1;
                    end else if (r_rise >= RW'(JUMP_STEPS) || (!jump_key && r_rise >= RW'(MIN_RISE_STEPS))) begin
                        w_state = FALL;
                        w_enter = 1'b1;
                    end else if (r_cnt == IW'(RISE_INV - 1)) begin
                        w_up   = 1'b1;
                        w_cnt  = '0;
                        w_rise = r_rise + 1'b1;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                FALL: begin
                    if (on_ground) begin
                        w_state = w_edge ? RISE : GROUND;
                        w_enter = 1'b1;
                        w_jl    = w_edge ? 2'(MAX_JUMPS - 1) : 2'(MAX_JUMPS);
                    end else if (w_edge && r_jl != 2'd0) begin
                        w_state = RISE;
                        w_enter = 1'b1;
                        w_jl    = r_jl - 2'd1;
                    end else if (r_cnt == r_finv - 1'b1) begin
                        w_down  = 1'b1;
                        w_cnt   = '0;
                        w_fstep = w_accel ? '0 : r_fstep + 1'b1;
                        w_finv  = (w_accel && r_finv > IW'(FALL_INV_MIN)) ? r_finv - 1'b1 : r_finv;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state = GROUND;
                    w_enter = 1'b1;
                end
            endcase
        end
        if (w_enter) begin
            w_cnt   = '0;
            w_rise  = '0;
            w_fstep = '0;
            w_finv  = IW'(FALL_INV_START);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rise  <= '0;
            r_fstep <= '0;
            r_finv  <= IW'(FALL_INV_START);
            r_jl    <= 2'(MAX_JUMPS);
            r_prev  <= 1'b1;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt;
            r_rise  <= w_rise;
            r_fstep <= w_fstep;
            r_finv  <= w_finv;
            r_jl    <= w_jl;
            r_prev  <= jump_key;
            r_up    <= w_up;
            r_down  <= w_down;
        end
    end

    assign dir_y      = r_state == RISE ? 2'b01 : r_state == FALL ? 2'b10 : 2'b00;
    assign air_action = r_state == RISE ? 2'b10 : r_state == FALL ? 2'b11 : 2'b00;
    assign is_up      = r_up;
    assign is_down    = r_down;
    assign jumps_left = r_jl;
endmodule

// File: tb/tb_jump_fall_ctrl.sv
// tb_jump_fall_ctrl: directed scenarios with literal timing checks plus random stimulus against a behavioural model
module tb_jump_fall_ctrl;
    localparam int MAXJ = 2, JS = 24, MINR = 6, RINV = 3, FS = 6, FM = 2, AS = 4;

    logic       clk = 1'b0, rst, jump_key, on_ground, hit_ceiling, pause;
    logic [1:0] dir_y, air_action, jumps_left;
    logic       is_up, is_down;

    jump_fall_ctrl dut (
        .clk(clk), .rst(rst), .jump_key(jump_key), .on_ground(on_ground),
        .hit_ceiling(hit_ceiling), .pause(pause), .dir_y(dir_y),
        .air_action(air_action), .is_up(is_up), .is_down(is_down),
        .jumps_left(jumps_left)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0;
    int m_mode, m_jl, m_age, m_ups, m_downs;
    bit m_prev, m_up, m_down, m_valid = 0, jedge;
    int up_q[$], down_q[$];
    int gaps[18] = '{6, 6, 6, 6, 5, 5, 5, 5, 4, 4, 4, 4, 3, 3, 3, 3, 2, 2};

    function automatic int fall_inv(input int downs);
        int v;
        v = FS - downs / AS;
        return v < FM ? FM : v;
    endfunction

    task automatic enter(input int mode, input int jl);
        m_mode  = mode;
        m_jl    = jl;
        m_age   = 0;
        m_ups   = 0;
        m_downs = 0;
    endtask

    always @(posedge clk) begin
        cyc++;
        m_up   = 0;
        m_down = 0;
        if (rst) begin
            enter(0, MAXJ);
            m_prev  = 1;
            m_valid = 1;
        end else begin
            jedge  = jump_key && !m_prev;
            m_prev = jump_key;
            if (!pause) begin
                if (m_mode == 0) begin
                    if (jedge) enter(1, MAXJ - 1);
                    else if (!on_ground) enter(2, MAXJ - 1);
                end else if (m_mode == 1) begin
                    if (hit_ceiling) enter(2, m_jl);
                    else if (jedge && m_jl > 0) enter(1, m_jl - 1);
                    else if (m_ups >= JS || (!jump_key && m_ups >= MINR)) enter(2, m_jl);
                    else begin
                        m_age++;
                        if (m_age == RINV) begin
                            m_up = 1;
                            m_age = 0;
                            m_ups++;
                        end
                    end
                end else begin
                    if (on_ground) enter(jedge ? 1 : 0, jedge ? MAXJ - 1 : MAXJ);
                    else if (jedge && m_jl > 0) enter(1, m_jl - 1);
                    else begin
                        m_age++;
                        if (m_age == fall_inv(m_downs)) begin
                            m_down = 1;
                            m_age = 0;
                            m_downs++;
                        end
                    end
                end
            end
        end
        #1;
        if (is_up) up_q.push_back(cyc);
        if (is_down) down_q.push_back(cyc);
    end

    always @(negedge clk) begin
        int ed, ea;
        if (m_valid) begin
            ed = m_mode == 1 ? 1 : m_mode == 2 ? 2 : 0;
            ea = m_mode == 1 ? 2 : m_mode == 2 ? 3 : 0;
            n_vec++;
            if (int'(dir_y) != ed || int'(air_action) != ea || is_up !== m_up || is_down !== m_down || int'(jumps_left) != m_jl) begin
                n_err++;
                $display("FAIL model cycle %0d: got dir=%0d air=%0d up=%0b dn=%0b jl=%0d, expected dir=%0d air=%0d up=%0b dn=%0b jl=%0d",
                         cyc, dir_y, air_action, is_up, is_down, jumps_left, ed, ea, m_up, m_down, m_jl);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic wait_up(input int n);
        for (int i = 0; i < 400 && up_q.size() < n; i++) tick(1);
        chk("wait_up", up_q.size(), n);
    endtask

    task automatic wait_down(input int n);
        for (int i = 0; i < 400 && down_q.size() < n; i++) tick(1);
        chk("wait_down", down_q.size(), n);
    endtask

    task automatic wait_air(input int a);
        for (int i = 0; i < 400 && int'(air_action) != a; i++) tick(1);
        chk("wait_air", int'(air_action), a);
    endtask

    initial begin
        int t;
        rst = 1; jump_key = 1; on_ground = 1; hit_ceiling = 0; pause = 0;
        tick(3);
        rst = 0;
        up_q.delete(); down_q.delete();
        tick(20);
        chk("held_key_no_up", up_q.size(), 0);
        chk("held_key_air", int'(air_action), 0);
        chk("held_key_jl", int'(jumps_left), 2);

        jump_key = 0; tick(1);
        jump_key = 1; tick(1);
        t = cyc; jump_key = 0;
        wait_up(6);
        chk("tap_first_up", up_q.size() > 0 ? up_q[0] - t : -1, 3);
        for (int k = 1; k < up_q.size(); k++) chk("tap_up_gap", up_q[k] - up_q[k-1], 3);
        tick(1);
        chk("tap_fall_air", int'(air_action), 3);
        chk("tap_fall_jl", int'(jumps_left), 1);
        tick(1);
        chk("tap_land_air", int'(air_action), 0);
        chk("tap_land_jl", int'(jumps_left), 2);
        tick(20);
        chk("tap_total_up", up_q.size(), 6);

        up_q.delete(); down_q.delete();
        jump_key = 1; tick(1);
        on_ground = 0;
        wait_up(24);
        for (int k = 1; k < up_q.size(); k++) chk("hold_up_gap", up_q[k] - up_q[k-1], 3);
        tick(1);
        chk("hold_fall_air", int'(air_action), 3);
        t = cyc;
        wait_down(18);
        for (int k = 0; k < down_q.size() && k < 18; k++)
            chk($sformatf("fall_gap%0d", k), down_q[k] - (k == 0 ? t : down_q[k-1]), gaps[k]);
        chk("hold_total_up", up_q.size(), 24);
        jump_key = 0; on_ground = 1; tick(1);
        chk("hold_land_air", int'(air_action), 0);
        chk("hold_land_jl", int'(jumps_left), 2);

        jump_key = 1; tick(1);
        on_ground = 0; tick(3);
        jump_key = 0; tick(1);
        jump_key = 1; tick(1);
        chk("dbl_jl", int'(jumps_left), 0);
        chk("dbl_air", int'(air_action), 2);
        t = cyc; up_q.delete();
        tick(7);
        chk("dbl_restart_up", up_q.size() > 0 ? up_q[0] - t : -1, 3);
        jump_key = 0; tick(1);
        jump_key = 1; tick(1);
        chk("third_jl", int'(jumps_left), 0);
        chk("third_air", int'(air_action), 2);
        jump_key = 0;
        wait_air(3);
        on_ground = 1; tick(1);
        chk("dbl_land_air", int'(air_action), 0);
        chk("dbl_land_jl", int'(jumps_left), 2);

        on_ground = 0; tick(1);
        chk("ledge_air", int'(air_action), 3);
        chk("ledge_jl", int'(jumps_left), 1);
        jump_key = 1; tick(1);
        chk("ledge_jump_air", int'(air_action), 2);
        chk("ledge_jump_jl", int'(jumps_left), 0);
        jump_key = 0; tick(1);
        jump_key = 1; tick(1);
        chk("ledge_extra_jl", int'(jumps_left), 0);
        chk("ledge_extra_air", int'(air_action), 2);
        jump_key = 0;
        wait_air(3);
        jump_key = 1; tick(1);
        chk("fall_extra_air", int'(air_action), 3);
        jump_key = 0; on_ground = 1; tick(1);
        chk("ledge_land_jl", int'(jumps_left), 2);

        up_q.delete(); down_q.delete();
        jump_key = 1; on_ground = 0; tick(1);
        wait_up(10);
        hit_ceiling = 1; tick(1);
        hit_ceiling = 0;
        chk("ceil_air", int'(air_action), 3);
        wait_down(2);
        tick(2);
        pause = 1; tick(8);
        chk("pause_no_down", down_q.size(), 2);
        chk("pause_air", int'(air_action), 3);
        pause = 0;
        wait_down(3);
        chk("pause_resume_gap", down_q.size() > 2 ? down_q[2] - down_q[1] : -1, 14);
        chk("ceil_total_up", up_q.size(), 10);
        jump_key = 0; on_ground = 1; tick(2);

        jump_key = 1; tick(1);
        on_ground = 0; tick(4);
        rst = 1; tick(1);
        chk("rst_air", int'(air_action), 0);
        chk("rst_jl", int'(jumps_left), 2);
        chk("rst_up", int'(is_up), 0);
        rst = 0; on_ground = 1; jump_key = 0; tick(2);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) jump_key = ~jump_key;
            if ($urandom_range(0, 29) == 0) on_ground = ~on_ground;
            hit_ceiling = $urandom_range(0, 24) == 0;
            if ($urandom_range(0, 39) == 0) pause = ~pause;
            rst = $urandom_range(0, 499) == 0;
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
